// File: rtl/branch_ctrl.sv
// Branch predictor (2-bit counter BHT) and EX mispredict redirect controller.
// Optional BRANCH_CTRL_PERF_EN adds br_count / mispred_count outputs.
module branch_ctrl #(
    parameter int BHT_ENTRIES = 16,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_br_taken,
    input  logic        ex_pred_taken,
    input  logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BRANCH_CTRL_PERF_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
`endif
);

    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam int CNTW = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;

    state_t            r_state;
    logic [1:0]        r_bht [BHT_ENTRIES];
    logic [CNTW-1:0]   r_sq_cnt;

    logic [IDXW-1:0]   w_if_idx;
    logic [IDXW-1:0]   w_ex_idx;
    logic              w_res;
    logic              w_mispred;
    logic              w_unused;

    assign w_if_idx   = if_pc[IDXW+1:2];
    assign w_ex_idx   = ex_pc[IDXW+1:2];
    assign w_res      = ex_valid & ex_branch & ~stall & (r_state == IDLE);
    assign w_mispred  = w_res & (ex_br_taken != ex_pred_taken);
    assign pred_taken = r_bht[w_if_idx][1];
    assign w_unused   = &{1'b0, if_pc};

    // Lookup reads the pre-update value, so same-index updates show next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_res) begin
            if (ex_br_taken && r_bht[w_ex_idx] != 2'b11)
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
            else if (!ex_br_taken && r_bht[w_ex_idx] != 2'b00)
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            r_sq_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mispred) begin
                        r_state        <= REDIRECT;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= ex_br_taken ? ex_target : ex_pc + 32'd4;
                    end
                end
                REDIRECT: begin
                    if (!stall) begin
                        r_state        <= SQUASH;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                        r_sq_cnt       <= CNTW'(FLUSH_DEPTH);
                    end
                end
                SQUASH: begin
                    // Wrong-path EX resolutions drain here; only advancing cycles count.
                    if (!stall) begin
                        r_sq_cnt <= r_sq_cnt - CNTW'(1);
                        if (r_sq_cnt <= CNTW'(1)) r_state <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= 32'h0;
            mispred_count <= 32'h0;
        end else begin
            if (w_res)     br_count      <= br_count + 32'd1;
            if (w_mispred) mispred_count <= mispred_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: prediction, mispredict redirect, squash, stall, reset.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_branch, ex_br_taken, ex_pred_taken, stall;
    logic [31:0] ex_pc, ex_target;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] br_count, mispred_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.BHT_ENTRIES(16), .FLUSH_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_br_taken   (ex_br_taken),
        .ex_pred_taken (ex_pred_taken),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef BRANCH_CTRL_PERF_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'h0, pred_taken}, {31'h0, exp});
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic ptaken);
        ex_valid = 1'b1; ex_branch = 1'b1;
        ex_pc = pc; ex_target = tgt;
        ex_br_taken = taken; ex_pred_taken = ptaken;
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'h0; stall = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_pc = 32'h0; ex_target = 32'h0;
        ex_br_taken = 1'b0; ex_pred_taken = 1'b0;
        #12;
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_rv", {31'h0, redirect_valid}, 32'h0);
        check("rst_rpc", redirect_pc, 32'h0);
        rst_n = 1'b1;
        step();

        for (int a = 0; a <= 32'h3C; a += 4) pred_at("sweep_pred", a, 1'b0);

        // Non-branch with mismatching prediction: no action.
        present(32'h100, 32'h80, 1'b1, 1'b0);
        ex_branch = 1'b0;
        step();
        check("nobr_flush", {31'h0, flush}, 32'h0);
        pred_at("nobr_pred", 32'h100, 1'b0);

        // Taken mispredict.
        present(32'h100, 32'h80, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        check("tk_flush", {31'h0, flush}, 32'h1);
        check("tk_rv", {31'h0, redirect_valid}, 32'h1);
        check("tk_rpc", redirect_pc, 32'h80);
        pred_at("tk_pred", 32'h100, 1'b1);
        step();
        check("tk_sq_flush", {31'h0, flush}, 32'h0);
        check("tk_sq_rv", {31'h0, redirect_valid}, 32'h0);
        step(); step();

        // Not-taken mispredict, then wrong-path squash.
        present(32'h200, 32'h999, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        check("nt_flush", {31'h0, flush}, 32'h1);
        check("nt_rpc", redirect_pc, 32'h204);
        pred_at("nt_pred", 32'h200, 1'b0);
        step();
        present(32'h300, 32'h500, 1'b1, 1'b0);
        step();
        check("sq1_flush", {31'h0, flush}, 32'h0);
        check("sq1_rv", {31'h0, redirect_valid}, 32'h0);
        step();
        check("sq2_flush", {31'h0, flush}, 32'h0);
        check("sq2_rv", {31'h0, redirect_valid}, 32'h0);
        pred_at("sq_pred", 32'h300, 1'b0);
        step();
        ex_valid = 1'b0;
        check("post_sq_flush", {31'h0, flush}, 32'h1);
        check("post_sq_rpc", redirect_pc, 32'h500);
        pred_at("post_sq_pred", 32'h300, 1'b1);
        step(); step(); step();

        // Saturation at 0x40 (index 0, counter currently 10).
        present(32'h40, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sat_flush", {31'h0, flush}, 32'h0);
        end
        pred_at("sat_pred", 32'h40, 1'b1);
        present(32'h40, 32'h0, 1'b0, 1'b0);
        step();
        pred_at("sat_nt1_pred", 32'h40, 1'b1);
        step();
        ex_valid = 1'b0;
        pred_at("sat_nt2_pred", 32'h40, 1'b0);
        check("sat_nt_flush", {31'h0, flush}, 32'h0);

        // Stall held in REDIRECT.
        present(32'h10, 32'h1234, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        stall = 1'b1;
        check("st_flush0", {31'h0, flush}, 32'h1);
        check("st_rpc", redirect_pc, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            step();
            check("st_flush_held", {31'h0, flush}, 32'h1);
            check("st_rv_held", {31'h0, redirect_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        check("st_sq_flush", {31'h0, flush}, 32'h0);
        present(32'h10, 32'h0, 1'b0, 1'b1);
        step();
        check("st_sq1_flush", {31'h0, flush}, 32'h0);
        step();
        check("st_sq2_flush", {31'h0, flush}, 32'h0);
        pred_at("st_pred", 32'h10, 1'b1);

        // Back in IDLE: not-taken mispredict at top of address space wraps.
        present(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        check("wrap_flush", {31'h0, flush}, 32'h1);
        check("wrap_rpc", redirect_pc, 32'h0);
`ifdef BRANCH_CTRL_PERF_EN
        check("perf_br", br_count, 32'd11);
        check("perf_mp", mispred_count, 32'd5);
`endif

        // Reset mid-REDIRECT.
        rst_n = 1'b0;
        #1;
        check("mrst_flush", {31'h0, flush}, 32'h0);
        check("mrst_rv", {31'h0, redirect_valid}, 32'h0);
        check("mrst_rpc", redirect_pc, 32'h0);
        pred_at("mrst_pred", 32'h10, 1'b0);
`ifdef BRANCH_CTRL_PERF_EN
        check("mrst_br", br_count, 32'h0);
`endif
        rst_n = 1'b1;
        step();
        check("mrst_idle_flush", {31'h0, flush}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
